// File: rtl/cp0_pkg.sv
// CP0 register numbers, cause codes, field positions and widths shared by the exception unit.
package cp0_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned IRQ_W  = 6;
  localparam int unsigned CODE_W = 5;
  localparam int unsigned REG_W  = 5;

  // Status / Cause field positions
  localparam int unsigned STATUS_IE     = 0;
  localparam int unsigned STATUS_EXL    = 1;
  localparam int unsigned STATUS_IM_LO  = 10;
  localparam int unsigned CAUSE_CODE_LO = 2;
  localparam int unsigned CAUSE_IP_LO   = 10;

  localparam logic [XLEN-1:0] EXC_VECTOR_DEFAULT = 32'h0000_0180;

  typedef enum logic [REG_W-1:0] {
    CP0_BADVADDR = 5'd8,
    CP0_STATUS   = 5'd12,
    CP0_CAUSE    = 5'd13,
    CP0_EPC      = 5'd14
  } cp0_reg_e;

  typedef enum logic [CODE_W-1:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Address-error causes are the only ones that latch BadVAddr.
  function automatic logic is_addr_fault(input logic [CODE_W-1:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/exception_unit_if.sv
// Pipeline <-> exception unit signal bundle.
interface exception_unit_if;
  import cp0_pkg::*;

  logic              excValid;
  logic [CODE_W-1:0] excCode;
  logic [XLEN-1:0]   excPc;
  logic [XLEN-1:0]   excBadAddr;
  logic              eretValid;
  logic [XLEN-1:0]   commitPc;
  logic [IRQ_W-1:0]  irq;
  logic [REG_W-1:0]  cp0Addr;
  logic [XLEN-1:0]   cp0Din;
  logic              cp0Write;
  logic [XLEN-1:0]   cp0Dout;
  logic              takeException;
  logic              takeEret;
  logic [XLEN-1:0]   epc;
  logic              flush;

  modport master (
    output excValid, excCode, excPc, excBadAddr, eretValid, commitPc, irq,
           cp0Addr, cp0Din, cp0Write,
    input  cp0Dout, takeException, takeEret, epc, flush
  );

  modport slave (
    input  excValid, excCode, excPc, excBadAddr, eretValid, commitPc, irq,
           cp0Addr, cp0Din, cp0Write,
    output cp0Dout, takeException, takeEret, epc, flush
  );

endinterface

// File: rtl/exception_unit_irq_sync.sv
// Two-flop synchronizer for the asynchronous interrupt lines.
module irq_sync
  import cp0_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IRQ_W-1:0] d,
  output logic [IRQ_W-1:0] q
);

  logic [IRQ_W-1:0] meta;

  // Both stages clear on reset so IP reads 0 afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/exception_unit.sv
// CP0 exception unit: Status/Cause/EPC/BadVAddr, event arbitration and PC redirect pulses.
module exception_unit
  import cp0_pkg::*;
#(
  parameter logic [XLEN-1:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
)
(
  input  logic             clk,
  input  logic             rst,
  exception_unit_if.slave  bus
);

  state_t            state;
  logic [IRQ_W-1:0]  im;
  logic              exl;
  logic              ie;
  logic [IRQ_W-1:0]  ip;
  logic [CODE_W-1:0] exc_code;
  logic [XLEN-1:0]   epc_q;
  logic [XLEN-1:0]   badvaddr;
  logic              take_exc;
  logic              take_eret;
  logic              flush_q;

  logic              in_run;
  logic              acc_exc;
  logic              acc_eret;
  logic              acc_int;
  logic              acc_any;
  logic [XLEN-1:0]   rd_data;

  // The handler address is applied by the PC; reduced here only so it is referenced.
  logic unused_vec;
  assign unused_vec = ^EXC_VECTOR;

  irq_sync u_irq_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.irq),
    .q   (ip)
  );

  // Event arbitration: exception beats ERET beats interrupt; nothing is accepted in FLUSH.
  always_comb begin
    in_run   = (state == ST_RUN);
    acc_exc  = in_run && bus.excValid;
    acc_eret = in_run && !bus.excValid && bus.eretValid;
    acc_int  = in_run && !bus.excValid && !bus.eretValid &&
               ie && !exl && ((ip & im) != '0);
    acc_any  = acc_exc || acc_eret || acc_int;
  end

  // FSM, CP0 register updates and registered redirect pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      im        <= '0;
      exl       <= 1'b0;
      ie        <= 1'b0;
      exc_code  <= '0;
      epc_q     <= '0;
      badvaddr  <= '0;
      take_exc  <= 1'b0;
      take_eret <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      state     <= acc_any ? ST_FLUSH : ST_RUN;
      take_exc  <= acc_exc || acc_int;
      take_eret <= acc_eret;
      flush_q   <= acc_any;

      if (acc_exc) begin
        exc_code <= bus.excCode;
        exl      <= 1'b1;
        // A nested exception keeps the original return address.
        if (!exl) begin
          epc_q <= bus.excPc;
        end
        if (is_addr_fault(bus.excCode)) begin
          badvaddr <= bus.excBadAddr;
        end
      end else if (acc_int) begin
        exc_code <= EXC_INT;
        exl      <= 1'b1;
        epc_q    <= bus.commitPc;
      end else if (acc_eret) begin
        exl <= 1'b0;
      end else if (in_run && bus.cp0Write) begin
        case (bus.cp0Addr)
          CP0_STATUS: begin
            im  <= bus.cp0Din[STATUS_IM_LO +: IRQ_W];
            exl <= bus.cp0Din[STATUS_EXL];
            ie  <= bus.cp0Din[STATUS_IE];
          end
          CP0_CAUSE:    exc_code <= bus.cp0Din[CAUSE_CODE_LO +: CODE_W];
          CP0_EPC:      epc_q    <= bus.cp0Din;
          CP0_BADVADDR: badvaddr <= bus.cp0Din;
          default: ;
        endcase
      end
    end
  end

  // MFC0 read mux; reflects register state before the next edge.
  always_comb begin
    rd_data = '0;
    case (bus.cp0Addr)
      CP0_STATUS: begin
        rd_data[STATUS_IM_LO +: IRQ_W] = im;
        rd_data[STATUS_EXL]            = exl;
        rd_data[STATUS_IE]             = ie;
      end
      CP0_CAUSE: begin
        rd_data[CAUSE_IP_LO +: IRQ_W]    = ip;
        rd_data[CAUSE_CODE_LO +: CODE_W] = exc_code;
      end
      CP0_EPC:      rd_data = epc_q;
      CP0_BADVADDR: rd_data = badvaddr;
      default: ;
    endcase
  end

  assign bus.cp0Dout       = rd_data;
  assign bus.takeException = take_exc;
  assign bus.takeEret      = take_eret;
  assign bus.flush         = flush_q;
  assign bus.epc           = epc_q;

endmodule
